// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage core. Detects load-use
//   hazards between ID and EX, flushes IF/ID and ID/EX on EX-resolved
//   redirects, and freezes the front of the pipe while a multi-cycle EX op
//   (mul/div) is in flight. A watchdog releases the freeze if the unit never
//   answers. Also produces WB->ID register-file bypass selects and two
//   saturating performance counters.
//
// Parameters
//   MC_TIMEOUT : cycles (start cycle included) before the watchdog releases
//                a multi-cycle stall; 2..65535
//   CNT_W      : performance counter width
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2 ID source operands and their use flags
//   ex_rd, ex_mem_read          EX destination and load flag
//   ex_redirect                 branch taken / jump resolved in EX
//   ex_mc_start, mc_done        multi-cycle unit issue / result-valid
//   wb_reg_write, wb_rd         WB register-file write port
//   pc_en, if_id_en, id_ex_en   pipeline register load enables
//   if_id_flush, id_ex_flush    load NOP / bubble into IF/ID, ID/EX
//   ex_mem_bubble               EX/MEM loads a bubble
//   id_byp_rs1/2                ID takes WB write data instead of RD1/RD2
//   mc_busy                     FSM state (1 = MC_BUSY); doubles as the
//                               state debug output
//   mc_timeout                  sticky watchdog flag
//   stall_cnt, flush_cnt        saturating stall-cycle / redirect counters
//
// Multi-cycle handshake: ex_mc_start is a single-cycle issue pulse from EX;
// the unit answers with a single-cycle mc_done pulse when its result is on
// the EX/MEM inputs. mc_done in the issue cycle means the op finished in one
// cycle and no freeze happens. Between issue and done (or watchdog) the PC,
// IF/ID and ID/EX hold and EX/MEM receives bubbles.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             ex_mc_start,
   input  logic             mc_done,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_bubble,
   output logic             id_byp_rs1,
   output logic             id_byp_rs2,
   output logic             mc_busy,
   output logic             mc_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   // busy_cnt counts cycles since issue; the watchdog fires on the busy
   // cycle where it reaches MC_TIMEOUT-1, i.e. MC_TIMEOUT cycles in total.
   localparam logic [15:0] BUSY_LAST = 16'(MC_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] busy_cnt, busy_cnt_nxt;
   logic        timeout_set;
   logic        redirect_acc;
   logic        lu;

   always_comb begin
      lu = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
            (id_use_rs2 && (id_rs2 == ex_rd)));
   end

   // Bypass is purely a register-index match and does not depend on state.
   assign id_byp_rs1 = !rst && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
   assign id_byp_rs2 = !rst && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);

   assign mc_busy = (state == MC_BUSY);

   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      state_nxt     = state;
      busy_cnt_nxt  = busy_cnt;
      timeout_set   = 1'b0;
      redirect_acc  = 1'b0;

      case (state)
         RUN: begin
            if (ex_redirect) begin
               // Wrong-path instructions in IF and ID are squashed; a
               // pending load-use stall belongs to the squashed ID op.
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               redirect_acc = 1'b1;
            end else if (ex_mc_start && !mc_done) begin
               pc_en         = 1'b0;
               if_id_en      = 1'b0;
               id_ex_en      = 1'b0;
               ex_mem_bubble = 1'b1;
               busy_cnt_nxt  = 16'd1;
               state_nxt     = MC_BUSY;
            end else if (ex_mc_start) begin
               // single-cycle completion: pipeline flows normally
            end else if (lu) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
         MC_BUSY: begin
            if (mc_done || (busy_cnt == BUSY_LAST)) begin
               timeout_set = !mc_done;
               state_nxt   = RUN;
               // The ID instruction resumes this cycle, so its load-use
               // check applies just as in RUN.
               if (lu) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end else begin
               pc_en         = 1'b0;
               if_id_en      = 1'b0;
               id_ex_en      = 1'b0;
               ex_mem_bubble = 1'b1;
               busy_cnt_nxt  = busy_cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase

      if (rst) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         busy_cnt <= 16'd0;
      end else begin
         state    <= state_nxt;
         busy_cnt <= busy_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_timeout <= 1'b0;
      end else if (timeout_set) begin
         mc_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (redirect_acc && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Two instances share one stimulus: dut_a with default parameters and
//   dut_b with MC_TIMEOUT=4, CNT_W=4 so the watchdog and counter saturation
//   are reachable in a few cycles. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later.
//   Control vectors are packed {pc_en, if_id_en, id_ex_en, if_id_flush,
//   id_ex_flush, ex_mem_bubble}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
   logic       ex_mc_start, mc_done, wb_reg_write;

   logic        a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_flush;
   logic        a_ex_mem_bubble, a_id_byp_rs1, a_id_byp_rs2, a_mc_busy, a_mc_timeout;
   logic [31:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush;
   logic        b_ex_mem_bubble, b_id_byp_rs1, b_id_byp_rs2, b_mc_busy, b_mc_timeout;
   logic [3:0]  b_stall_cnt, b_flush_cnt;

   logic [5:0] a_ctl, b_ctl;
   logic [9:0] a_vec, b_vec;
   assign a_ctl = {a_pc_en, a_if_id_en, a_id_ex_en, a_if_id_flush, a_id_ex_flush, a_ex_mem_bubble};
   assign b_ctl = {b_pc_en, b_if_id_en, b_id_ex_en, b_if_id_flush, b_id_ex_flush, b_ex_mem_bubble};
   assign a_vec = {a_ctl, a_id_byp_rs1, a_id_byp_rs2, a_mc_busy, a_mc_timeout};
   assign b_vec = {b_ctl, b_id_byp_rs1, b_id_byp_rs2, b_mc_busy, b_mc_timeout};

   localparam logic [5:0] C_RUN   = 6'b111000;
   localparam logic [5:0] C_RST   = 6'b000111;
   localparam logic [5:0] C_FRZ   = 6'b000001;
   localparam logic [5:0] C_LU    = 6'b001010;
   localparam logic [5:0] C_REDIR = 6'b111110;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_ctrl dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .ex_mc_start(ex_mc_start), .mc_done(mc_done),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush),
      .id_ex_en(a_id_ex_en), .id_ex_flush(a_id_ex_flush),
      .ex_mem_bubble(a_ex_mem_bubble), .id_byp_rs1(a_id_byp_rs1),
      .id_byp_rs2(a_id_byp_rs2), .mc_busy(a_mc_busy), .mc_timeout(a_mc_timeout),
      .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .ex_mc_start(ex_mc_start), .mc_done(mc_done),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush),
      .id_ex_en(b_id_ex_en), .id_ex_flush(b_id_ex_flush),
      .ex_mem_bubble(b_ex_mem_bubble), .id_byp_rs1(b_id_byp_rs1),
      .id_byp_rs2(b_id_byp_rs2), .mc_busy(b_mc_busy), .mc_timeout(b_mc_timeout),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // A redirect and a multi-cycle issue cannot come from the same EX op.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(ex_redirect && ex_mc_start))
            else $error("illegal ex_redirect with ex_mc_start");
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
      ex_mc_start = 1'b0; mc_done = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0;
   endtask

   task automatic drive_lu();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_idle();
      wb_reg_write = 1'b1; wb_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7;
      drive_lu();
      ex_redirect = 1'b1;
      #3;
      n_checks++;
      if (a_vec !== {C_RST, 4'b0000}) begin
         n_fail++; $display("FAIL reset_a_outputs: got %b want %b", a_vec, {C_RST, 4'b0000});
      end
      n_checks++;
      if (b_vec !== {C_RST, 4'b0000}) begin
         n_fail++; $display("FAIL reset_b_outputs: got %b want %b", b_vec, {C_RST, 4'b0000});
      end
      n_checks++;
      if (a_stall_cnt !== 32'd0 || a_flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt);
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      drive_lu();
      #1;
      n_checks++;
      if (a_ctl !== C_LU) begin
         n_fail++; $display("FAIL lu_stall: got %b want %b", a_ctl, C_LU);
      end
      tick();
      ex_mem_read = 1'b0;
      #1;
      n_checks++;
      if (a_ctl !== C_RUN) begin
         n_fail++; $display("FAIL lu_resume: got %b want %b", a_ctl, C_RUN);
      end
      n_checks++;
      if (a_stall_cnt !== 32'd1 || b_stall_cnt !== 4'd1) begin
         n_fail++; $display("FAIL lu_stall_cnt: got %0d/%0d want 1/1", a_stall_cnt, b_stall_cnt);
      end
   endtask

   task automatic test_no_hazard();
      do_reset();
      drive_lu();
      ex_rd = 5'd0; id_rs1 = 5'd0;
      #1;
      n_checks++;
      if (a_ctl !== C_RUN) begin
         n_fail++; $display("FAIL nolu_rd0: got %b want %b", a_ctl, C_RUN);
      end
      tick();
      drive_lu();
      id_use_rs1 = 1'b0;
      #1;
      n_checks++;
      if (a_ctl !== C_RUN) begin
         n_fail++; $display("FAIL nolu_unused: got %b want %b", a_ctl, C_RUN);
      end
      tick();
      #1;
      n_checks++;
      if (a_stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL nolu_stall_cnt: got %0d want 0", a_stall_cnt);
      end
      id_use_rs2 = 1'b1; id_rs2 = 5'd5;
      #1;
      n_checks++;
      if (a_ctl !== C_LU) begin
         n_fail++; $display("FAIL lu_rs2: got %b want %b", a_ctl, C_LU);
      end
      tick();
   endtask

   task automatic test_redirect();
      do_reset();
      drive_lu();
      ex_redirect = 1'b1;
      #1;
      n_checks++;
      if (a_ctl !== C_REDIR) begin
         n_fail++; $display("FAIL redirect_ctl: got %b want %b", a_ctl, C_REDIR);
      end
      tick();
      drive_idle();
      #1;
      n_checks++;
      if (a_flush_cnt !== 32'd1 || a_stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL redirect_cnt: got flush %0d stall %0d want 1/0", a_flush_cnt, a_stall_cnt);
      end
   endtask

   task automatic test_mc();
      do_reset();
      ex_mc_start = 1'b1;
      #1;
      n_checks++;
      if ({a_ctl, a_mc_busy} !== {C_FRZ, 1'b0}) begin
         n_fail++; $display("FAIL mc_issue: got %b want %b", {a_ctl, a_mc_busy}, {C_FRZ, 1'b0});
      end
      tick();
      ex_mc_start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ex_redirect = (i == 2);
         #1;
         n_checks++;
         if ({a_ctl, a_mc_busy} !== {C_FRZ, 1'b1}) begin
            n_fail++; $display("FAIL mc_hold_%0d: got %b want %b", i, {a_ctl, a_mc_busy}, {C_FRZ, 1'b1});
         end
         tick();
      end
      ex_redirect = 1'b0;
      mc_done = 1'b1;
      #1;
      n_checks++;
      if ({a_ctl, a_mc_busy} !== {C_RUN, 1'b1}) begin
         n_fail++; $display("FAIL mc_release: got %b want %b", {a_ctl, a_mc_busy}, {C_RUN, 1'b1});
      end
      tick();
      mc_done = 1'b0;
      #1;
      n_checks++;
      if ({a_mc_busy, a_mc_timeout} !== 2'b00 || a_stall_cnt !== 32'd5 || a_flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL mc_after: got busy/to %b stall %0d flush %0d want 00/5/0",
                            {a_mc_busy, a_mc_timeout}, a_stall_cnt, a_flush_cnt);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      ex_mc_start = 1'b1;
      tick();
      ex_mc_start = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         n_checks++;
         if ({b_ctl, b_mc_busy} !== {C_FRZ, 1'b1}) begin
            n_fail++; $display("FAIL to_hold_%0d: got %b want %b", i, {b_ctl, b_mc_busy}, {C_FRZ, 1'b1});
         end
         tick();
      end
      #1;
      n_checks++;
      if ({b_ctl, b_mc_busy, b_mc_timeout} !== {C_RUN, 2'b10}) begin
         n_fail++; $display("FAIL to_release: got %b want %b", {b_ctl, b_mc_busy, b_mc_timeout}, {C_RUN, 2'b10});
      end
      tick();
      #1;
      n_checks++;
      if ({b_ctl, b_mc_busy, b_mc_timeout} !== {C_RUN, 2'b01} || b_stall_cnt !== 4'd3) begin
         n_fail++; $display("FAIL to_fired: got %b stall %0d want %b stall 3",
                            {b_ctl, b_mc_busy, b_mc_timeout}, b_stall_cnt, {C_RUN, 2'b01});
      end
      n_checks++;
      if ({a_mc_busy, a_mc_timeout} !== 2'b10) begin
         n_fail++; $display("FAIL to_a_still_busy: got %b want 10", {a_mc_busy, a_mc_timeout});
      end
      tick(); tick(); tick();
      #1;
      n_checks++;
      if (b_mc_timeout !== 1'b1) begin
         n_fail++; $display("FAIL to_sticky: got %b want 1", b_mc_timeout);
      end
      mc_done = 1'b1;
      tick();
      mc_done = 1'b0;
   endtask

   task automatic test_bypass();
      do_reset();
      wb_reg_write = 1'b1; wb_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3;
      #1;
      n_checks++;
      if ({a_id_byp_rs1, a_id_byp_rs2} !== 2'b01) begin
         n_fail++; $display("FAIL byp_rs2: got %b want 01", {a_id_byp_rs1, a_id_byp_rs2});
      end
      wb_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      #1;
      n_checks++;
      if ({a_id_byp_rs1, a_id_byp_rs2} !== 2'b00) begin
         n_fail++; $display("FAIL byp_x0: got %b want 00", {a_id_byp_rs1, a_id_byp_rs2});
      end
      wb_rd = 5'd9; id_rs1 = 5'd9; wb_reg_write = 1'b0;
      #1;
      n_checks++;
      if ({a_id_byp_rs1, a_id_byp_rs2} !== 2'b00) begin
         n_fail++; $display("FAIL byp_nowrite: got %b want 00", {a_id_byp_rs1, a_id_byp_rs2});
      end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      ex_mc_start = 1'b1;
      tick();
      ex_mc_start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #1;
      n_checks++;
      if ({a_mc_busy, b_mc_timeout} !== 2'b11) begin
         n_fail++; $display("FAIL rmid_pre: got %b want 11", {a_mc_busy, b_mc_timeout});
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({a_mc_busy, a_mc_timeout, b_mc_busy, b_mc_timeout} !== 4'b0000 ||
          a_stall_cnt !== 32'd0 || b_stall_cnt !== 4'd0) begin
         n_fail++; $display("FAIL rmid_async: got %b stall %0d/%0d want 0000 0/0",
                            {a_mc_busy, a_mc_timeout, b_mc_busy, b_mc_timeout}, a_stall_cnt, b_stall_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({a_ctl, a_mc_busy} !== {C_RUN, 1'b0}) begin
         n_fail++; $display("FAIL rmid_after: got %b want %b", {a_ctl, a_mc_busy}, {C_RUN, 1'b0});
      end
   endtask

   task automatic test_saturation();
      do_reset();
      drive_lu();
      for (int i = 0; i < 20; i++) tick();
      drive_idle();
      ex_redirect = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      ex_redirect = 1'b0;
      #1;
      n_checks++;
      if (a_stall_cnt !== 32'd20 || b_stall_cnt !== 4'd15) begin
         n_fail++; $display("FAIL sat_stall: got %0d/%0d want 20/15", a_stall_cnt, b_stall_cnt);
      end
      n_checks++;
      if (a_flush_cnt !== 32'd20 || b_flush_cnt !== 4'hF) begin
         n_fail++; $display("FAIL sat_flush: got %0d/%0d want 20/15", a_flush_cnt, b_flush_cnt);
      end
   endtask

   // Reference model: per instance, whether a multi-cycle op is outstanding,
   // how many cycles have passed since it was issued, and the counters as
   // plain integers clipped at the counter maximum.
   task automatic test_random();
      bit     m_busy [2];
      int     m_wait [2];
      bit     m_to   [2];
      longint m_stall[2];
      longint m_flush[2];
      int     lim    [2];
      longint cmax   [2];
      bit     lu, byp1, byp2, acc;
      logic [5:0]  e_ctl;
      logic [9:0]  e_vec, act_vec;
      logic [31:0] act_stall, act_flush, e_stall, e_flush;
      lim[0] = 64; lim[1] = 4;
      cmax[0] = 64'h0000_0000_FFFF_FFFF; cmax[1] = 64'd15;
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_wait[k] = 0; m_to[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         id_rs1 = 5'($urandom_range(0, 3));
         id_rs2 = 5'($urandom_range(0, 3));
         ex_rd  = 5'($urandom_range(0, 3));
         wb_rd  = 5'($urandom_range(0, 3));
         id_use_rs1   = 1'($urandom_range(0, 1));
         id_use_rs2   = 1'($urandom_range(0, 1));
         wb_reg_write = 1'($urandom_range(0, 1));
         ex_mem_read  = ($urandom_range(0, 2) == 0);
         ex_redirect  = ($urandom_range(0, 7) == 0);
         ex_mc_start  = !ex_redirect && ($urandom_range(0, 5) == 0);
         mc_done      = ($urandom_range(0, 6) == 0);
         #1;
         lu = ex_mem_read && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         byp1 = wb_reg_write && wb_rd != 0 && wb_rd == id_rs1;
         byp2 = wb_reg_write && wb_rd != 0 && wb_rd == id_rs2;
         for (int k = 0; k < 2; k++) begin
            e_ctl = C_RUN;
            acc   = 0;
            e_vec = {e_ctl, byp1, byp2, m_busy[k], m_to[k]};
            e_stall = m_stall[k][31:0];
            e_flush = m_flush[k][31:0];
            if (!m_busy[k]) begin
               if (ex_redirect) begin
                  e_ctl = C_REDIR; acc = 1;
               end else if (ex_mc_start && !mc_done) begin
                  e_ctl = C_FRZ; m_busy[k] = 1; m_wait[k] = 1;
               end else if (!ex_mc_start && lu) begin
                  e_ctl = C_LU;
               end
            end else if (mc_done || m_wait[k] + 1 == lim[k]) begin
               // unit answered, or it has now had lim cycles since issue
               if (!mc_done) m_to[k] = 1;
               m_busy[k] = 0;
               if (lu) e_ctl = C_LU;
            end else begin
               e_ctl = C_FRZ; m_wait[k]++;
            end
            e_vec[9:4] = e_ctl;
            act_vec   = (k == 0) ? a_vec : b_vec;
            act_stall = (k == 0) ? a_stall_cnt : {28'd0, b_stall_cnt};
            act_flush = (k == 0) ? a_flush_cnt : {28'd0, b_flush_cnt};
            n_checks++;
            if (act_vec !== e_vec) begin
               n_fail++; $display("FAIL rand_outputs dut%0d cyc %0d: got %b want %b", k, cyc, act_vec, e_vec);
            end
            n_checks++;
            if (act_stall !== e_stall || act_flush !== e_flush) begin
               n_fail++; $display("FAIL rand_counters dut%0d cyc %0d: got %0d/%0d want %0d/%0d",
                                  k, cyc, act_stall, act_flush, e_stall, e_flush);
            end
            if (!e_ctl[5] && m_stall[k] < cmax[k]) m_stall[k]++;
            if (acc && m_flush[k] < cmax[k]) m_flush[k]++;
         end
         tick();
      end
      drive_idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_redirect();
      test_mc();
      test_timeout();
      test_bypass();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
